mult_iter_hs: RTL and testbench

Iterative radix-2 shift-add multiplier with a valid/ready handshake on both sides and a per-operation signed/unsigned mode. It takes over from the single-cycle IP multiplier wrapper wherever area matters more than throughput, and produces the same full-width 2*WL product. It sits between operand producers and online-arithmetic consumers that can tolerate a WL-cycle latency.

---
 rtl/mult_iter_hs_if.sv | 8 +
 rtl/mult_iter_hs.sv | 56 +++++
 tb/tb_mult_iter_hs.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mult_iter_hs_if.sv
// mult_iter_hs_if: operand/result valid-ready bundle for mult_iter_hs
interface mult_iter_hs_if #(parameter int WL = 9);
    logic in_valid, in_ready, is_signed, out_valid, out_ready, busy;
    logic [WL-1:0] A, B;
    logic [2*WL-1:0] Sum;
    modport master (output in_valid, is_signed, A, B, out_ready, input in_ready, out_valid, Sum, busy);
    modport slave (input in_valid, is_signed, A, B, out_ready, output in_ready, out_valid, Sum, busy);
endinterface

// File: rtl/mult_iter_hs.sv
// mult_iter_hs: iterative radix-2 shift-add multiplier, sign-magnitude, valid/ready on both sides
module mult_iter_hs #(parameter int WL = 9) (
    input logic clk,
    input logic rst_n,
    mult_iter_hs_if.slave io
);
    localparam int CW = $clog2(WL);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;
    logic [2*WL-1:0] acc, mcand, acc_nxt, sum;
    logic [WL-1:0] mplier, mag_a, mag_b;
    logic [CW-1:0] cnt;
    logic neg, last;
    assign mag_a = (io.is_signed & io.A[WL-1]) ? -io.A : io.A;
    assign mag_b = (io.is_signed & io.B[WL-1]) ? -io.B : io.B;
    assign last = cnt == CW'(WL-1);
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        if (state == IDLE && io.in_valid) state_nxt = CALC;
        else if (state == CALC && last) state_nxt = DONE;
        else if (state == DONE && io.out_ready) state_nxt = IDLE;
    end
    // the multiplicand shifts left so the current weight is always mcand itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
            cnt <= '0;
            neg <= 1'b0;
            sum <= '0;
        end else if (state == IDLE) begin
            if (io.in_valid) begin
                acc <= '0;
                mcand <= {{WL{1'b0}}, mag_a};
                mplier <= mag_b;
                cnt <= '0;
                neg <= io.is_signed & (io.A[WL-1] ^ io.B[WL-1]);
            end
        end else if (state == CALC) begin
            acc <= acc_nxt;
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            cnt <= cnt + CW'(1);
            if (last) sum <= neg ? -acc_nxt : acc_nxt;
        end
    end
    assign io.in_ready = state == IDLE;
    assign io.out_valid = state == DONE;
    assign io.busy = state != IDLE;
    assign io.Sum = sum;
endmodule

// File: tb/tb_mult_iter_hs.sv
// tb_mult_iter_hs: directed vectors against a cycle-level arithmetic model of mult_iter_hs
module tb_mult_iter_hs;
    localparam int WL = 9;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int m_left = 0;
    logic m_done = 1'b0;
    logic [2*WL-1:0] m_sum = '0;
    logic [2*WL-1:0] m_pend = '0;
    mult_iter_hs_if #(.WL(WL)) bus ();
    mult_iter_hs #(.WL(WL)) dut (.clk(clk), .rst_n(rst_n), .io(bus));
    always #5 clk = ~clk;
    function automatic logic [2*WL-1:0] prod(input logic [WL-1:0] a, input logic [WL-1:0] b, input logic s);
        logic [2*WL-1:0] ea, eb;
        ea = s ? {{WL{a[WL-1]}}, a} : {{WL{1'b0}}, a};
        eb = s ? {{WL{b[WL-1]}}, b} : {{WL{1'b0}}, b};
        return ea * eb;
    endfunction
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask
    // accept -> WL cycles of work -> hold the result until out_ready
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_sum <= '0;
        end else if (m_done) begin
            if (bus.out_ready) m_done <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_sum <= m_pend;
            end
        end else if (bus.in_valid) begin
            m_left <= WL;
            m_pend <= prod(bus.A, bus.B, bus.is_signed);
        end
    always @(negedge clk) begin
        chk("cyc_in_ready", bus.in_ready, !m_done && m_left == 0);
        chk("cyc_out_valid", bus.out_valid, m_done);
        chk("cyc_busy", bus.busy, m_done || m_left != 0);
        chk("cyc_sum", bus.Sum, m_sum);
    end
    task automatic run_op(input logic [WL-1:0] a, input logic [WL-1:0] b, input logic s,
                          input logic [2*WL-1:0] exp, input string nm);
        int n;
        n = 0;
        while (!bus.in_ready && n < 40) begin @(negedge clk); n++; end
        chk({nm, "_in_ready"}, bus.in_ready, 1);
        bus.A = a;
        bus.B = b;
        bus.is_signed = s;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.A = '1;
        bus.B = '1;
        bus.is_signed = ~s;
        n = 0;
        while (!bus.out_valid && n < 40) begin @(negedge clk); n++; end
        chk({nm, "_latency"}, n, WL);
        chk({nm, "_sum"}, bus.Sum, exp);
        chk({nm, "_model"}, m_sum, exp);
        if (bus.out_ready) @(negedge clk);
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.is_signed = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_sum", bus.Sum, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(9'd511, 9'd511, 1'b0, 18'h3FC01, "umax");
        run_op(9'h100, 9'h100, 1'b1, 18'h10000, "smax");
        run_op(9'h100, 9'h0FF, 1'b1, 18'h30100, "mixed_s");
        run_op(9'h100, 9'h0FF, 1'b0, 18'h0FF00, "mixed_u");
        run_op(9'h000, 9'h1FF, 1'b1, 18'h00000, "negzero");
        run_op(9'h1FF, 9'h1FF, 1'b1, 18'h00001, "m1m1");
        bus.out_ready = 1'b0;
        run_op(9'd3, 9'd5, 1'b0, 18'd15, "bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = (i == 2);
            bus.A = 9'd7;
            bus.B = 9'd7;
            chk("bp_sum", bus.Sum, 15);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", bus.in_ready, 1);
        chk("bp_release_out_valid", bus.out_valid, 0);
        chk("bp_release_sum", bus.Sum, 15);
        bus.A = 9'd5;
        bus.B = 9'd6;
        bus.is_signed = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_sum", bus.Sum, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(9'd7, 9'h1FE, 1'b1, 18'h3FFF2, "after_rst");
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
